// File: rtl/cpa_pipe_pkg.sv
// Shared multiplier datapath package: widths and the prefix slice bundle
// carried between the register stages of the final adder.
package cpa_pipe_pkg;

   localparam int W             = 66;
   localparam int PREFIX_LEVELS = 7;

   typedef struct packed {
      logic [W-1:0] g;
      logic [W-1:0] p;
      logic [W-1:0] p0;
      logic         cin;
      logic         valid;
   } slice_t;

endpackage

// File: rtl/cpa_pipe_pretree.sv
// One Kogge-Stone prefix level; STAGE=k combines each bit with the
// group 2^(k-1) positions below it.
module cpa_pipe_pretree
   import cpa_pipe_pkg::*;
#(
   parameter int STAGE = 1
) (
   input  slice_t d,
   output slice_t q
);

   localparam int SPAN = 1 << (STAGE - 1);

   always_comb begin
      q = d;
      for (int i = SPAN; i < W; i++) begin
         q.g[i] = d.g[i] | (d.p[i] & d.g[i-SPAN]);
         q.p[i] = d.p[i] & d.p[i-SPAN];
      end
   end

endmodule

// File: rtl/cpa_pipe.sv
// Pipelined Kogge-Stone carry-propagate adder with valid/ready and flush.
// Define CPA_STALL_CNT_EN to add the saturating output stall counter.
module cpa_pipe
   import cpa_pipe_pkg::*;
#(
   parameter logic [6:0] PIPE_MASK = 7'b0001000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_cout
`ifdef CPA_STALL_CNT_EN
   ,
   output logic [15:0]  stall_cnt
`endif
);

   localparam int L = PREFIX_LEVELS;
   // Bit 0 is the always-present input register.
   localparam logic [L:0] REG_MASK = {PIPE_MASK, 1'b1};

   slice_t       d_in [0:L];
   slice_t       st   [0:L];
   logic         rdy  [0:L+1];
   slice_t       fin;
   logic [W-1:0] carry;

   always_comb begin
      d_in[0].g     = in_a & in_b;
      d_in[0].p     = in_a ^ in_b;
      d_in[0].p0    = in_a ^ in_b;
      d_in[0].cin   = in_cin;
      d_in[0].valid = in_valid;
   end

   for (genvar k = 1; k <= L; k++) begin : g_lvl
      cpa_pipe_pretree #(.STAGE(k)) u_pt (
         .d (st[k-1]),
         .q (d_in[k])
      );
   end

   assign rdy[L+1] = out_ready;

   for (genvar k = 0; k <= L; k++) begin : g_slc
      if (REG_MASK[k]) begin : g_reg
         slice_t slice_d;
         slice_t slice_q;

         assign rdy[k] = !slice_q.valid | rdy[k+1];
         assign st[k]  = slice_q;

         always_comb begin
            slice_d = slice_q;
            if (rdy[k]) slice_d = d_in[k];
            if (flush) slice_d.valid = 1'b0;
         end

         always_ff @(posedge clock or posedge reset) begin
            if (reset) slice_q <= '0;
            else       slice_q <= slice_d;
         end
      end else begin : g_thru
         assign rdy[k] = rdy[k+1];
         assign st[k]  = d_in[k];
      end
   end

   assign fin   = st[L];
   assign carry = {fin.g[W-2:0] | (fin.p[W-2:0] & {(W-1){fin.cin}}),
                   fin.cin};

   assign out_sum   = fin.p0 ^ carry;
   assign out_cout  = fin.g[W-1] | (fin.p[W-1] & fin.cin);
   assign out_valid = fin.valid;
   assign in_ready  = rdy[0];

`ifdef CPA_STALL_CNT_EN
   logic [15:0] stall_cnt_d;
   logic [15:0] stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cpa_pipe.sv
// Scoreboard bench for cpa_pipe: random operands vs a+b+cin reference,
// handshake, back-pressure, flush and async reset scenarios.
module tb_cpa_pipe;

   localparam logic [6:0] MASK = 7'b0001000;
   localparam int NS = 1 + $countones(MASK);

   logic        clock;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [65:0] in_a;
   logic [65:0] in_b;
   logic        in_cin;
   logic        out_valid;
   logic        out_ready;
   logic [65:0] out_sum;
   logic        out_cout;
`ifdef CPA_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   cpa_pipe #(.PIPE_MASK(MASK)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
`ifdef CPA_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int          n_chk = 0;
   int          n_fail = 0;
   int          stall_in = 0;
   int          acc_cnt = 0;
   int          lat;
   logic [66:0] exp_q [$];

   task automatic chk(input string name, input logic [66:0] got,
                      input logic [66:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   function automatic logic [65:0] rnd66();
      case ($urandom_range(0, 7))
         0:       return '1;
         1:       return '0;
         default: return {2'($urandom), $urandom, $urandom};
      endcase
   endfunction

   function automatic logic [66:0] model(input logic [65:0] a,
                                         input logic [65:0] b,
                                         input logic c);
      return {1'b0, a} + {1'b0, b} + 67'(c);
   endfunction

   task automatic step(input bit v, input logic [65:0] a,
                       input logic [65:0] b, input logic c);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_cin   = c;
      @(negedge clock);
      if (v && !in_ready) stall_in++;
      if (v && in_ready && !flush) begin
         exp_q.push_back(model(a, b, c));
         acc_cnt++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic rstep(input bit v);
      step(v, rnd66(), rnd66(), 1'($urandom));
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      repeat (3) @(posedge clock);
      #1;
      chk("drain_empty", 67'(exp_q.size()), 67'd0);
   endtask

   logic        hold_prev = 1'b0;
   logic        flush_prev = 1'b0;
   logic [66:0] val_prev = '0;

   always @(negedge clock) begin
      if (reset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev && !flush_prev) begin
            chk("hold_valid", 67'(out_valid), 67'd1);
            chk("hold_data", {out_cout, out_sum}, val_prev);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_out: got %h required none",
                        {out_cout, out_sum});
            end else begin
               chk("result", {out_cout, out_sum}, exp_q.pop_front());
            end
         end
         hold_prev  = out_valid && !out_ready;
         val_prev   = {out_cout, out_sum};
         flush_prev = flush;
      end
   end

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_out_valid", 67'(out_valid), 67'd0);
      chk("rst_out_sum", 67'(out_sum), 67'd0);
      chk("rst_out_cout", 67'(out_cout), 67'd0);
      chk("rst_in_ready", 67'(in_ready), 67'd1);
      #2 reset = 1'b0;
      @(posedge clock);
      #1;
`ifdef CPA_STALL_CNT_EN
      chk("rst_stall_cnt", 67'(stall_cnt), 67'd0);
`endif

      // Directed wrap-around and latency
      out_ready = 1'b1;
      step(1'b1, '1, 66'd1, 1'b0);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk("latency_wrap", 67'(lat), 67'(NS));
      chk("wrap_sum", {out_cout, out_sum}, {1'b1, 66'd0});

      step(1'b1, 66'h123, 66'h456, 1'b1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
      end
      chk("latency_small", 67'(lat), 67'(NS));
      chk("small_sum", {out_cout, out_sum}, 67'h57A);
      drain();

      // Back-to-back stream
      stall_in = 0;
      out_ready = 1'b1;
      repeat (20) rstep(1'b1);
      chk("b2b_in_ready_drops", 67'(stall_in), 67'd0);
      drain();

      // Back-pressure: only NS items fit
      out_ready = 1'b0;
      acc_cnt = 0;
      repeat (5) rstep(1'b1);
      chk("bp_accepts", 67'(acc_cnt), 67'(NS));
      chk("bp_in_ready", 67'(in_ready), 67'd0);
      out_ready = 1'b1;
      repeat (5) rstep(1'b1);
      drain();

      // Random traffic with random consumer stalls
      repeat (300) begin
         out_ready = ($urandom_range(0, 3) != 0);
         rstep($urandom_range(0, 3) != 0);
      end
      drain();

      // Flush a full pipe; the flush-cycle input is dropped
      out_ready = 1'b0;
      repeat (4) rstep(1'b1);
      flush = 1'b1;
      rstep(1'b1);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 67'(out_valid), 67'd0);
      chk("flush_in_ready", 67'(in_ready), 67'd1);
      exp_q.delete();
      out_ready = 1'b1;
      repeat (10) @(posedge clock);
      #1;
      drain();

      // Async reset between edges
      out_ready = 1'b0;
      repeat (3) rstep(1'b1);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_out_valid", 67'(out_valid), 67'd0);
      chk("arst_out_sum", {out_cout, out_sum}, 67'd0);
      exp_q.delete();
      @(negedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
`ifdef CPA_STALL_CNT_EN
      chk("arst_stall_cnt", 67'(stall_cnt), 67'd0);
      out_ready = 1'b0;
      rstep(1'b1);
      in_valid = 1'b0;
      repeat (70000) @(posedge clock);
      #1;
      chk("stall_cnt_sat", 67'(stall_cnt), 67'h0FFFF);
`endif
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
